// File: rtl/bignum_pkg.sv
// Shared definitions for the bignum datapath blocks.
// Provides default word/number widths, the byte-packer state type and an
// index-width helper that stays legal for single-entry ranges.
package bignum_pkg;

  localparam int unsigned REGISTER_SIZE_DEF = 32;
  localparam int unsigned BITS_IN_NUM_DEF   = 4096;

  typedef enum logic {
    FILLING  = 1'b0,
    DRAINING = 1'b1
  } packer_state_t;

  // Bits needed to index n entries; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_lane_assembler.sv
// Assembles accepted bytes little-endian into one REGISTER_SIZE-bit word.
// Ports:
//   clk_in, rst_in   clock, asynchronous active-low reset
//   i_byte           byte to insert
//   i_accept         byte handshake (valid && ready) this cycle
//   o_last_lane_c    combinational: next accepted byte completes a word
//   o_word           assembled word, valid while o_word_valid is high
//   o_word_valid     one-cycle pulse after the final byte of a word
module byte_lane_assembler
  import bignum_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [7:0]               i_byte,
  input  logic                     i_accept,
  output logic                     o_last_lane_c,
  output logic [REGISTER_SIZE-1:0] o_word,
  output logic                     o_word_valid
);

  localparam int unsigned BYTES_PER_WORD = REGISTER_SIZE / 8;
  localparam int unsigned LANE_W         = idx_width(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0]        r_lane;
  logic [REGISTER_SIZE-1:0] r_shift;
  logic                     r_word_valid;

  assign o_last_lane_c = (r_lane == LAST_LANE);
  assign o_word        = r_shift;
  assign o_word_valid  = r_word_valid;

  // New bytes enter at the top and move down, so byte 0 ends in bits [7:0].
  // The shift register itself is the word output: it cannot change before
  // the pulse is consumed because the next byte arrives at least one cycle later.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_lane       <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_accept && o_last_lane_c;
      if (i_accept) begin
        r_shift <= (r_shift >> 8) | (REGISTER_SIZE'(i_byte) << (REGISTER_SIZE - 8));
        r_lane  <= o_last_lane_c ? '0 : r_lane + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/byte_packer.sv
// Packs a serial byte stream into REGISTER_SIZE-bit words, buffers one full
// BITS_IN_NUM-bit number, then streams the words out with valid/ready/last.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   data_in/valid_in/ready_out  byte input handshake
//   data_out/valid_out/ready_in word output handshake
//   last_out                  marks word NUM_BLOCKS-1
module byte_packer
  import bignum_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE = REGISTER_SIZE_DEF,
  parameter int unsigned BITS_IN_NUM   = BITS_IN_NUM_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [7:0]               data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     last_out
);

  localparam int unsigned NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int unsigned IDX_W      = idx_width(NUM_BLOCKS);
  localparam int unsigned CNT_W      = $clog2(NUM_BLOCKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0] RD_ALL   = CNT_W'(NUM_BLOCKS);

  packer_state_t            r_state;
  packer_state_t            w_state_nxt;
  logic                     r_ready;
  logic                     w_ready_nxt;
  logic [IDX_W-1:0]         r_wr_idx;
  logic [CNT_W-1:0]         r_rd_cnt;
  logic [REGISTER_SIZE-1:0] r_mem [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] r_data_out;
  logic                     r_valid_out;
  logic                     r_last_out;

  logic                     w_accept;
  logic                     w_last_lane;
  logic [REGISTER_SIZE-1:0] w_word;
  logic                     w_word_valid;
  logic [IDX_W-1:0]         w_fill_idx;
  logic                     w_last_byte;
  logic                     w_wr_last;
  logic [IDX_W-1:0]         w_rd_addr;
  logic                     w_load;
  logic                     w_fire;
  logic                     w_drain_done;

  assign ready_out = r_ready;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign last_out  = r_last_out;

  assign w_accept = valid_in && r_ready;

  byte_lane_assembler #(
    .REGISTER_SIZE(REGISTER_SIZE)
  ) u_assembler (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_byte       (data_in),
    .i_accept     (w_accept),
    .o_last_lane_c(w_last_lane),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Index of the word the current byte belongs to; accounts for a write
  // still pending from the previous word (matters for 8-bit words).
  assign w_fill_idx   = w_word_valid ? r_wr_idx + IDX_W'(1) : r_wr_idx;
  assign w_last_byte  = w_accept && w_last_lane && (w_fill_idx == LAST_IDX);
  assign w_wr_last    = w_word_valid && (r_wr_idx == LAST_IDX);

  // Prefetch: reload the output register whenever it is empty or being taken.
  assign w_rd_addr    = r_rd_cnt[IDX_W-1:0];
  assign w_load       = (r_state == DRAINING) && (r_rd_cnt != RD_ALL) &&
                        (!r_valid_out || ready_in);
  assign w_fire       = r_valid_out && ready_in;
  assign w_drain_done = w_fire && r_last_out;

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= FILLING;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILLING:  if (w_wr_last)    w_state_nxt = DRAINING;
      DRAINING: if (w_drain_done) w_state_nxt = FILLING;
      default:                    w_state_nxt = FILLING;
    endcase
  end

  // Output logic: ready drops as soon as the final byte is taken so nothing
  // of the next number slips in before the last word is written.
  always_comb begin
    w_ready_nxt = 1'b0;
    case (r_state)
      FILLING:  w_ready_nxt = !(w_last_byte || w_wr_last);
      DRAINING: w_ready_nxt = w_drain_done;
      default:  w_ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_ready <= 1'b0;
    else         r_ready <= w_ready_nxt;
  end

  // Word buffer write port (no reset so it maps onto a RAM).
  always_ff @(posedge clk_in) begin
    if (w_word_valid) r_mem[r_wr_idx] <= w_word;
  end

  // Write and read counters.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_idx <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_word_valid) r_wr_idx <= w_wr_last ? '0 : r_wr_idx + IDX_W'(1);
      if (w_drain_done) r_rd_cnt <= '0;
      else if (w_load)  r_rd_cnt <= r_rd_cnt + CNT_W'(1);
    end
  end

  // Output register doubles as the buffer read register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end else if (w_load) begin
      r_data_out  <= r_mem[w_rd_addr];
      r_valid_out <= 1'b1;
      r_last_out  <= (w_rd_addr == LAST_IDX);
    end else if (w_fire) begin
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
    end
  end

endmodule
